axi4_shared_pattern_master: RTL and testbench

AXI4_SHARED_PATTERN_MASTER -- requirements
Module: axi4_shared_pattern_master

---
 rtl/axi4_shared_pattern_master.sv | 198 +++++++++++++++++++
 tb/tb_axi4_shared_pattern_master.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_shared_pattern_master.sv
// AXI4-shared pattern initiator: writes BURST_COUNT bursts of an address-derived
// pattern, reads them back, and counts mismatching or bad responses.
module axi4_shared_pattern_master #(
    parameter int unsigned ADDR_WIDTH  = 25,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned BURST_COUNT = 16,
    parameter logic [31:0] SEED        = 32'hA5A5A5A5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             error_count,
    output logic                    io_axi_arw_valid,
    input  logic                    io_axi_arw_ready,
    output logic [ADDR_WIDTH-1:0]   io_axi_arw_payload_addr,
    output logic [ID_WIDTH-1:0]     io_axi_arw_payload_id,
    output logic [7:0]              io_axi_arw_payload_len,
    output logic [2:0]              io_axi_arw_payload_size,
    output logic [1:0]              io_axi_arw_payload_burst,
    output logic                    io_axi_arw_payload_write,
    output logic                    io_axi_w_valid,
    input  logic                    io_axi_w_ready,
    output logic [DATA_WIDTH-1:0]   io_axi_w_payload_data,
    output logic [DATA_WIDTH/8-1:0] io_axi_w_payload_strb,
    output logic                    io_axi_w_payload_last,
    input  logic                    io_axi_b_valid,
    output logic                    io_axi_b_ready,
    input  logic [ID_WIDTH-1:0]     io_axi_b_payload_id,
    input  logic [1:0]              io_axi_b_payload_resp,
    input  logic                    io_axi_r_valid,
    output logic                    io_axi_r_ready,
    input  logic [DATA_WIDTH-1:0]   io_axi_r_payload_data,
    input  logic [ID_WIDTH-1:0]     io_axi_r_payload_id,
    input  logic [1:0]              io_axi_r_payload_resp,
    input  logic                    io_axi_r_payload_last
);

    localparam int unsigned KW = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
    localparam int unsigned JW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [KW-1:0] KLAST = KW'(BURST_COUNT - 1);
    localparam logic [JW-1:0] JLAST = JW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        WR_RESP,
        RD_CMD,
        RD_DATA,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [JW-1:0]   j_q, j_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            bad;

    logic [ID_WIDTH-1:0]   cur_id;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  cmd_active;
    logic                  beat_last;

    // Address is truncated to ADDR_WIDTH; data is the flat beat index XOR SEED.
    assign cur_id    = ID_WIDTH'(k_q);
    assign cur_addr  = ADDR_WIDTH'(64'(k_q) * 64'(BURST_LEN) * 64'd4);
    assign beat_data = DATA_WIDTH'((32'(k_q) * 32'(BURST_LEN) + 32'(j_q)) ^ SEED);
    assign beat_last = (j_q == JLAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        bad     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WR_CMD;
                    k_d     = '0;
                    j_d     = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            WR_CMD: begin
                if (io_axi_arw_ready) begin
                    state_d = WR_DATA;
                    j_d     = '0;
                end
            end
            WR_DATA: begin
                if (io_axi_w_ready) begin
                    if (beat_last) begin
                        j_d     = '0;
                        state_d = WR_RESP;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (io_axi_b_valid) begin
                    bad = (io_axi_b_payload_resp != 2'b00) || (io_axi_b_payload_id != cur_id);
                    if (k_q == KLAST) begin
                        k_d     = '0;
                        state_d = RD_CMD;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = WR_CMD;
                    end
                end
            end
            RD_CMD: begin
                if (io_axi_arw_ready) begin
                    state_d = RD_DATA;
                    j_d     = '0;
                end
            end
            RD_DATA: begin
                if (io_axi_r_valid) begin
                    bad = (io_axi_r_payload_data != beat_data) ||
                          (io_axi_r_payload_resp != 2'b00) ||
                          (io_axi_r_payload_id != cur_id) ||
                          (io_axi_r_payload_last != beat_last);
                    // Beat count alone ends the burst; a wrong last flag is only an error.
                    if (beat_last) begin
                        j_d = '0;
                        if (k_q == KLAST) begin
                            k_d     = '0;
                            state_d = DONE;
                        end else begin
                            k_d     = k_q + 1'b1;
                            state_d = RD_CMD;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (bad) begin
            err_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign cmd_active = (state_q == WR_CMD) || (state_q == RD_CMD);

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign error       = err_q;
    assign error_count = cnt_q;

    assign io_axi_arw_valid         = cmd_active;
    assign io_axi_arw_payload_addr  = cmd_active ? cur_addr : '0;
    assign io_axi_arw_payload_id    = cmd_active ? cur_id : '0;
    assign io_axi_arw_payload_len   = cmd_active ? 8'(BURST_LEN - 1) : '0;
    assign io_axi_arw_payload_size  = cmd_active ? 3'b010 : '0;
    assign io_axi_arw_payload_burst = cmd_active ? 2'b01 : '0;
    assign io_axi_arw_payload_write = (state_q == WR_CMD);

    assign io_axi_w_valid        = (state_q == WR_DATA);
    assign io_axi_w_payload_data = io_axi_w_valid ? beat_data : '0;
    assign io_axi_w_payload_strb = io_axi_w_valid ? '1 : '0;
    assign io_axi_w_payload_last = io_axi_w_valid && beat_last;

    assign io_axi_b_ready = (state_q == WR_RESP);
    assign io_axi_r_ready = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi4_shared_pattern_master.sv
// Bench for axi4_shared_pattern_master: memory-backed responder with optional
// backpressure/fault injection, checked against a transaction-level model.
module tb_axi4_shared_pattern_master;

    localparam int unsigned AW   = 25;
    localparam int unsigned IDW  = 2;
    localparam int unsigned LEN  = 8;
    localparam int unsigned CNT  = 16;
    localparam logic [31:0] SEED = 32'hA5A5A5A5;

    logic clk;
    logic reset;
    logic start;
    logic busy, done, error;
    logic [15:0] error_count;
    logic arw_valid, arw_ready;
    logic [AW-1:0] arw_addr;
    logic [IDW-1:0] arw_id;
    logic [7:0] arw_len;
    logic [2:0] arw_size;
    logic [1:0] arw_burst;
    logic arw_write;
    logic w_valid, w_ready;
    logic [31:0] w_data;
    logic [3:0] w_strb;
    logic w_last;
    logic b_valid, b_ready;
    logic [IDW-1:0] b_id;
    logic [1:0] b_resp;
    logic r_valid, r_ready;
    logic [31:0] r_data;
    logic [IDW-1:0] r_id;
    logic [1:0] r_resp;
    logic r_last;

    axi4_shared_pattern_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ID_WIDTH(IDW),
        .BURST_LEN(LEN), .BURST_COUNT(CNT), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .error(error), .error_count(error_count),
        .io_axi_arw_valid(arw_valid), .io_axi_arw_ready(arw_ready),
        .io_axi_arw_payload_addr(arw_addr), .io_axi_arw_payload_id(arw_id),
        .io_axi_arw_payload_len(arw_len), .io_axi_arw_payload_size(arw_size),
        .io_axi_arw_payload_burst(arw_burst), .io_axi_arw_payload_write(arw_write),
        .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
        .io_axi_w_payload_data(w_data), .io_axi_w_payload_strb(w_strb),
        .io_axi_w_payload_last(w_last),
        .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready),
        .io_axi_b_payload_id(b_id), .io_axi_b_payload_resp(b_resp),
        .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
        .io_axi_r_payload_data(r_data), .io_axi_r_payload_id(r_id),
        .io_axi_r_payload_resp(r_resp), .io_axi_r_payload_last(r_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    // Control requests from the test sequence
    bit rst_req, start_req;
    // Responder modes
    bit bp, rnd_fault, corrupt21, berr_all;

    // Transaction-level model of the pass
    bit m_busy, m_done, m_zero, m_wr_phase;
    int unsigned m_inj, m_k, m_j;

    // Responder state
    logic [31:0] mem [128];
    bit rsp_bpend, rsp_rpend;
    int unsigned rsp_beat, cmd_base;
    logic [IDW-1:0] cmd_id;

    // Statistics and literal pins
    int unsigned wr_bursts, rd_bursts, wbeats, rbeats;
    bit first_w_seen;
    logic [31:0] first_wdata;
    logic [AW-1:0] burst1_addr;

    bit p_arw_stall, p_w_stall;
    logic [63:0] p_arw_pl, p_w_pl;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [31:0] pat(input int unsigned k, input int unsigned j);
        return (k * LEN + j) ^ SEED;
    endfunction

    task automatic check_outputs();
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("error", error, m_inj != 0);
        chk("error_count", error_count, (m_inj > 65535) ? 65535 : m_inj);
        if (!m_busy) begin
            chk("idle_valids_readies", {arw_valid, w_valid, b_ready, r_ready}, 0);
        end
        if (m_zero) begin
            chk("zero_arw_payload", {arw_addr, arw_id, arw_len, arw_size, arw_burst, arw_write}, 0);
            chk("zero_w_payload", {w_data, w_strb, w_last}, 0);
        end
        if (p_arw_stall) begin
            chk("arw_hold_valid", arw_valid, 1);
            chk("arw_hold_payload", {arw_addr, arw_id, arw_len, arw_size, arw_burst, arw_write}, p_arw_pl);
        end
        if (p_w_stall) begin
            chk("w_hold_valid", w_valid, 1);
            chk("w_hold_payload", {w_data, w_strb, w_last}, p_w_pl);
        end
    endtask

    task automatic clear_inputs();
        arw_ready = 0; w_ready = 0;
        b_valid = 0; b_id = 0; b_resp = 0;
        r_valid = 0; r_data = 0; r_id = 0; r_resp = 0; r_last = 0;
    endtask

    task automatic respond();
        bit bad;
        int unsigned f;
        arw_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        w_ready   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;

        if (rsp_bpend && (!bp || $urandom_range(0, 2) != 0)) begin
            b_valid = 1; b_id = cmd_id; b_resp = berr_all ? 2'b10 : 2'b00;
            if (rnd_fault && $urandom_range(0, 7) == 0) begin
                f = $urandom_range(1, 3);
                if (f[0]) b_resp = 2'($urandom_range(1, 3));
                if (f[1]) b_id = b_id ^ 2'b01;
            end
        end else if (!rsp_bpend && bp && $urandom_range(0, 7) == 0) begin
            b_valid = 1; b_id = 2'($urandom); b_resp = 2'($urandom);
        end else begin
            b_valid = 0; b_id = 0; b_resp = 0;
        end

        if (rsp_rpend && (!bp || $urandom_range(0, 2) != 0)) begin
            r_valid = 1; r_id = cmd_id; r_resp = 0;
            r_data = mem[(cmd_base + rsp_beat) % 128];
            r_last = (rsp_beat == LEN - 1);
            if (corrupt21 && cmd_base / LEN == 2 && rsp_beat == 3) r_data = r_data ^ 32'h1;
            if (rnd_fault && $urandom_range(0, 15) == 0) begin
                f = $urandom_range(1, 15);
                if (f[0]) r_data = r_data ^ (32'h1 << $urandom_range(0, 31));
                if (f[1]) r_resp = 2'($urandom_range(1, 3));
                if (f[2]) r_id = r_id ^ 2'b01;
                if (f[3]) r_last = ~r_last;
            end
        end else if (!rsp_rpend && bp && $urandom_range(0, 7) == 0) begin
            r_valid = 1; r_data = $urandom; r_id = 2'($urandom); r_resp = 2'($urandom); r_last = 1'($urandom);
        end else begin
            r_valid = 0; r_data = 0; r_id = 0; r_resp = 0; r_last = 0;
        end

        // DUT outputs depend only on its state, so handshakes for the coming edge are known now.
        if (arw_valid && arw_ready) begin
            chk("arw_addr", arw_addr, AW'(m_k * LEN * 4));
            chk("arw_id", arw_id, IDW'(m_k));
            chk("arw_len_size_burst", {arw_len, arw_size, arw_burst}, {8'(LEN - 1), 3'b010, 2'b01});
            chk("arw_write", arw_write, m_wr_phase);
            if (m_wr_phase && m_k == 1) burst1_addr = arw_addr;
            cmd_id = arw_id; cmd_base = 32'(arw_addr) >> 2; rsp_beat = 0; m_j = 0;
            if (!arw_write) rsp_rpend = 1;
        end
        if (w_valid && w_ready) begin
            chk("w_data", w_data, pat(m_k, m_j));
            chk("w_strb_last", {w_strb, w_last}, {4'hF, m_j == LEN - 1});
            if (!first_w_seen) begin first_wdata = w_data; first_w_seen = 1; end
            mem[(cmd_base + rsp_beat) % 128] = w_data;
            rsp_beat++; wbeats++; m_j++;
            if (rsp_beat == LEN) rsp_bpend = 1;
        end
        if (b_valid && b_ready) begin
            if (b_resp != 0 || b_id != IDW'(m_k)) m_inj++;
            rsp_bpend = 0; wr_bursts++;
            if (m_k == CNT - 1) begin m_k = 0; m_wr_phase = 0; end
            else m_k++;
        end
        if (r_valid && r_ready) begin
            bad = (r_data != pat(m_k, m_j)) || (r_resp != 0) || (r_id != IDW'(m_k)) ||
                  (r_last != (m_j == LEN - 1));
            if (bad) m_inj++;
            rsp_beat++; rbeats++;
            if (m_j == LEN - 1) begin
                rsp_rpend = 0; rd_bursts++; m_j = 0;
                if (m_k == CNT - 1) begin m_busy = 0; m_done = 1; m_k = 0; end
                else m_k++;
            end else begin
                m_j++;
            end
        end

        p_arw_stall = arw_valid && !arw_ready;
        p_arw_pl    = {arw_addr, arw_id, arw_len, arw_size, arw_burst, arw_write};
        p_w_stall   = w_valid && !w_ready;
        p_w_pl      = {w_data, w_strb, w_last};
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        reset = !rst_req;
        start = start_req;
        if (rst_req) begin
            m_busy = 0; m_done = 0; m_inj = 0; m_zero = 1;
            rsp_bpend = 0; rsp_rpend = 0; rsp_beat = 0;
            p_arw_stall = 0; p_w_stall = 0;
            clear_inputs();
        end else begin
            if (start_req && !m_busy) begin
                m_busy = 1; m_done = 0; m_inj = 0; m_zero = 0;
                m_wr_phase = 1; m_k = 0; m_j = 0;
                wr_bursts = 0; rd_bursts = 0; wbeats = 0; rbeats = 0;
            end
            respond();
        end
    endtask

    task automatic do_reset(input int unsigned n);
        rst_req = 1;
        repeat (n) cycle();
        rst_req = 0;
        repeat (2) cycle();
    endtask

    task automatic run_pass(input int extra_at);
        start_req = 1; cycle(); start_req = 0;
        cycle();
        for (int c = 0; c < 5000 && done !== 1'b1; c++) begin
            if (c == extra_at) start_req = 1;
            cycle();
            start_req = 0;
        end
        chk("pass_completes", done, 1);
        cycle();
        chk("write_bursts", wr_bursts, CNT);
        chk("read_bursts", rd_bursts, CNT);
        chk("write_beats", wbeats, CNT * LEN);
        chk("read_beats", rbeats, CNT * LEN);
    endtask

    initial begin
        reset = 0; start = 0;
        clear_inputs();
        rst_req = 1; start_req = 0;
        bp = 0; rnd_fault = 0; corrupt21 = 0; berr_all = 0;
        m_busy = 0; m_done = 0; m_zero = 1; m_inj = 0; m_wr_phase = 1; m_k = 0; m_j = 0;
        rsp_bpend = 0; rsp_rpend = 0; rsp_beat = 0; cmd_base = 0; cmd_id = 0;
        p_arw_stall = 0; p_w_stall = 0; p_arw_pl = 0; p_w_pl = 0;
        first_w_seen = 0; first_wdata = 0; burst1_addr = '1;
        wr_bursts = 0; rd_bursts = 0; wbeats = 0; rbeats = 0;
        foreach (mem[i]) mem[i] = '0;

        // Start asserted while in reset is ignored
        start_req = 1;
        do_reset(4);
        start_req = 0;
        repeat (2) cycle();

        // Ideal pass with a stray start mid-pass
        run_pass(30);
        chk("ideal_error_count", error_count, 16'd0);
        chk("first_wdata_literal", first_wdata, 32'hA5A5A5A5);
        chk("burst1_addr_literal", burst1_addr, 25'h20);

        // One corrupted read beat (burst 2 beat 3); started straight from DONE
        corrupt21 = 1;
        run_pass(-1);
        chk("corrupt_error", error, 1);
        chk("corrupt_error_count", error_count, 16'd1);
        corrupt21 = 0;

        // Restart after done clears the error state
        run_pass(-1);
        chk("restart_error_count", error_count, 16'd0);

        // Every write response SLVERR
        berr_all = 1;
        run_pass(-1);
        chk("slverr_error_count", error_count, 16'd16);
        berr_all = 0;

        // Random backpressure and valid gaps, clean data
        bp = 1;
        run_pass(-1);
        chk("bp_error_count", error_count, 16'd0);

        // Random backpressure plus random response faults
        rnd_fault = 1;
        run_pass(-1);
        chk("fault_error_count", error_count, 16'(m_inj));
        bp = 0; rnd_fault = 0;

        // Reset while write beat 4 of the first burst is pending
        start_req = 1; cycle(); start_req = 0;
        for (int c = 0; c < 200 && wbeats < 4; c++) cycle();
        chk("reached_beat4", wbeats, 4);
        chk("beat4_w_valid", w_valid, 1);
        do_reset(2);
        chk("post_reset_busy_done", {busy, done, error}, 0);
        chk("post_reset_count", error_count, 0);

        run_pass(-1);
        chk("clean_after_reset_count", error_count, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
